k_dsp_issue: RTL and testbench

Instruction issue stage sitting directly upstream of the K_DSP ALU. It accepts 16-bit instructions over a valid/ready handshake and decodes them. It reads two operands from an internal 8×32 register file, drives the ALU's `opA`/`opB`/`selector` inputs for one cycle, and writes the ALU result back into the register file. It also executes load-immediate locally and traps divide-by-zero before it reaches the ALU.

---
 rtl/k_dsp_issue.sv | 131 +++++++++++++
 tb/tb_k_dsp_issue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/k_dsp_issue.sv
// Instruction issue stage for the K_DSP ALU: decodes 16-bit instructions, reads an
// 8x32 register file, drives the ALU for one cycle and writes the result back.
module k_dsp_issue #(
  parameter int NREGS = 8,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr,
  output logic [XLEN-1:0] opA,
  output logic [XLEN-1:0] opB,
  output logic [2:0]      selector,
  output logic            alu_valid,
  input  logic [XLEN-1:0] alu_result,
  output logic            done,
  output logic            err,
  input  logic [2:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b111;

  state_t          state_q, state_d;
  logic [15:4]     instr_q, instr_d;
  logic [XLEN-1:0] opA_q, opA_d;
  logic [XLEN-1:0] opB_q, opB_d;
  logic [2:0]      sel_q, sel_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] regs_q [NREGS];

  logic [2:0]      op_q, rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_ext;

  assign op_q  = instr_q[15:13];
  assign rd_q  = instr_q[12:10];
  assign rs1_q = instr_q[9:7];
  assign rs2_q = instr_q[6:4];

  // r0 is hardwired to zero on every read path
  assign rs1_val  = (rs1_q == 3'd0) ? '0 : regs_q[rs1_q];
  assign rs2_val  = (rs2_q == 3'd0) ? '0 : regs_q[rs2_q];
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];
  assign imm_ext  = {{(XLEN-10){1'b0}}, instr[9:0]};

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    sel_d     = sel_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr[15:4];
          err_d   = 1'b0;
          if (instr[15:13] == OP_LDI) begin
            wb_data_d = imm_ext;
            state_d   = S_WB;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        opA_d = rs1_val;
        opB_d = rs2_val;
        sel_d = op_q;
        // Divide-by-zero is trapped here so the ALU never sees it
        if (op_q == OP_DIV && rs2_val == '0) begin
          wb_data_d = '1;
          err_d     = 1'b1;
          state_d   = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wb_data_d = alu_result;
        state_d   = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      sel_q     <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      sel_q     <= sel_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
      if (state_q == S_WB && rd_q != 3'd0) regs_q[rd_q] <= wb_data_q;
    end
  end

  assign instr_ready = rst_n && (state_q == S_IDLE);
  assign alu_valid   = (state_q == S_EXEC);
  assign done        = (state_q == S_WB);
  assign err         = (state_q == S_WB) && err_q;
  assign opA         = opA_q;
  assign opB         = opB_q;
  assign selector    = sel_q;

endmodule

// File: tb/tb_k_dsp_issue.sv
// Directed bench for k_dsp_issue: table of instructions with hand-computed results,
// plus reset-state and reset-during-EXEC sequences.
module tb_k_dsp_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [31:0] opA, opB;
  logic [2:0]  selector;
  logic        alu_valid;
  logic [31:0] alu_result;
  logic        done, err;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  k_dsp_issue #(.NREGS(8), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opA(opA), .opB(opB), .selector(selector), .alu_valid(alu_valid),
    .alu_result(alu_result), .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU
  always_comb begin
    case (selector)
      3'b000:  alu_result = opA + opB;
      3'b001:  alu_result = opA & opB;
      3'b010:  alu_result = opB >> 8;
      3'b011:  alu_result = opB >> 16;
      3'b100:  alu_result = (opB == 0) ? 32'hFFFF_FFFF : opA / opB;
      3'b101:  alu_result = opA - opB;
      default: alu_result = 32'h0;
    endcase
  end

  typedef struct {
    logic [15:0] ins;
    int          lat;
    int          nvld;
    logic [31:0] a, b;
    logic [2:0]  s;
    logic        e;
    logic [2:0]  rd;
    logic [31:0] val;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rr(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] r1, input logic [2:0] r2);
    return {op, rd, r1, r2, 4'b0};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
    return {3'b111, rd, imm};
  endfunction

  // Issue one instruction and observe it until done (bounded)
  task automatic run(input logic [15:0] ins, output int lat, output int nvld,
                     output logic [31:0] a, output logic [31:0] b, output logic [2:0] s,
                     output logic e);
    int w;
    lat = 0; nvld = 0; a = 'x; b = 'x; s = 'x; e = 1'bx;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (alu_valid) begin
        nvld++;
        a = opA; b = opB; s = selector;
      end
      if (done) begin
        lat = n;
        e = err;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int lat, nvld;
    logic [31:0] a, b;
    logic [2:0]  s;
    logic        e;
    int          seen_done;

    //              ins                           lat nv  a         b         s     e  rd  val
    vecs[0]  = '{ldi(3'd1, 10'd5),                1, 0, 0,        0,        0,    0, 1, 32'd5};
    vecs[1]  = '{ldi(3'd2, 10'd3),                1, 0, 0,        0,        0,    0, 2, 32'd3};
    vecs[2]  = '{rr(3'b000, 3'd3, 3'd1, 3'd2),    3, 1, 32'd5,    32'd3,    3'd0, 0, 3, 32'd8};
    vecs[3]  = '{rr(3'b101, 3'd4, 3'd3, 3'd1),    3, 1, 32'd8,    32'd5,    3'd5, 0, 4, 32'd3};
    vecs[4]  = '{ldi(3'd5, 10'd0),                1, 0, 0,        0,        0,    0, 5, 32'd0};
    vecs[5]  = '{rr(3'b100, 3'd6, 3'd1, 3'd5),    2, 0, 0,        0,        0,    1, 6, 32'hFFFF_FFFF};
    vecs[6]  = '{ldi(3'd0, 10'h3FF),              1, 0, 0,        0,        0,    0, 0, 32'd0};
    vecs[7]  = '{rr(3'b000, 3'd7, 3'd0, 3'd1),    3, 1, 32'd0,    32'd5,    3'd0, 0, 7, 32'd5};
    vecs[8]  = '{rr(3'b100, 3'd6, 3'd3, 3'd2),    3, 1, 32'd8,    32'd3,    3'd4, 0, 6, 32'd2};
    vecs[9]  = '{ldi(3'd2, 10'h3FF),              1, 0, 0,        0,        0,    0, 2, 32'h3FF};
    vecs[10] = '{rr(3'b010, 3'd5, 3'd0, 3'd2),    3, 1, 32'd0,    32'h3FF,  3'd2, 0, 5, 32'd3};
    vecs[11] = '{rr(3'b001, 3'd4, 3'd2, 3'd1),    3, 1, 32'h3FF,  32'd5,    3'd1, 0, 4, 32'd5};

    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    dbg_addr = 3'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, instr_ready}, 32'd0);
    chk("rst_alu_valid", {31'b0, alu_valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_opA", opA, 32'd0);
    chk("rst_opB", opB, 32'd0);
    chk("rst_sel", {29'b0, selector}, 32'd0);
    chk("rst_r3", dbg_data, 32'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", {31'b0, instr_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      dbg_addr = vecs[i].rd;
      run(vecs[i].ins, lat, nvld, a, b, s, e);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_alu_valid_cycles", i), nvld, vecs[i].nvld);
      chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vecs[i].e});
      if (vecs[i].nvld == 1) begin
        chk($sformatf("v%0d_opA", i), a, vecs[i].a);
        chk($sformatf("v%0d_opB", i), b, vecs[i].b);
        chk($sformatf("v%0d_sel", i), {29'b0, s}, {29'b0, vecs[i].s});
      end
      chk($sformatf("v%0d_reg", i), dbg_data, vecs[i].val);
    end

    // Reset while an ADD is in EXEC: no writeback, no done
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(ldi(3'd1, 10'd5), lat, nvld, a, b, s, e);
    run(ldi(3'd2, 10'd3), lat, nvld, a, b, s, e);
    dbg_addr = 3'd3;
    instr = rr(3'b000, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_exec_reached", {31'b0, alu_valid}, 32'd1);
    rst_n = 1'b0;
    seen_done = 0;
    @(posedge clk);
    @(negedge clk);
    if (done) seen_done++;
    chk("mid_ready_in_rst", {31'b0, instr_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_ready_after", {31'b0, instr_ready}, 32'd1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("mid_no_done", seen_done, 0);
    chk("mid_r3_zero", dbg_data, 32'd0);
    dbg_addr = 3'd1;
    #1 chk("mid_r1_cleared", dbg_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
